// File: rtl/mp3_ui_renderer.sv
// MP3 player UI pixel renderer: button tiles, volume bar,
// progressively revealed cover art and a frame border.
module mp3_ui_renderer #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int N_BTN       = 4,
  parameter int BTN_SZ      = 32,
  parameter int HOLD_FRAMES = 8,
  parameter int VOL_LEVELS  = 8,
  parameter int VOL_FRAMES  = 60,
  parameter int COVER_W     = 50,
  parameter int COVER_H     = 50,
  parameter int REVEAL_STEP = 1,
  parameter int BORDER_W    = 15
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic signed [15:0]                      i_x,
  input  logic signed [15:0]                      i_y,
  input  logic                                    i_vs,
  input  logic [N_BTN-1:0]                        i_btn,
  input  logic [$clog2(VOL_LEVELS+1)-1:0]         i_vol_level,
  input  logic                                    i_restart,
  output logic [$clog2(COVER_W*COVER_H)-1:0]      o_addr,
  input  logic [11:0]                             i_rom_data,
  output logic [3:0]                              o_red,
  output logic [3:0]                              o_green,
  output logic [3:0]                              o_blue
);

  typedef logic signed [16:0] s17_t;
  typedef enum logic [1:0] {C_FIX, C_TEX, C_BRD} cls_t;

  localparam int NPIX  = COVER_W * COVER_H;
  localparam int AW    = $clog2(NPIX);
  localparam int RW    = $clog2(NPIX + 1);
  localparam int RW1   = RW + 1;
  localparam int LW    = $clog2(VOL_LEVELS + 1);
  localparam int HW    = $clog2(HOLD_FRAMES + 1);
  localparam int VW    = $clog2(VOL_FRAMES + 1);
  localparam int PITCH = 2 * BTN_SZ;
  localparam int TX0   = (H_RES - (N_BTN-1)*PITCH - BTN_SZ) / 2;
  localparam int TY0   = V_RES * 3 / 4;
  localparam int SEG_W = 2 * BTN_SZ / 4;
  localparam int SEG_H = BTN_SZ / 4;
  localparam int VX0   = H_RES/2 - SEG_W/2;
  localparam int VB    = TY0 - SEG_H;
  localparam int VTOP  = VB - VOL_LEVELS*SEG_H;
  localparam int CX0   = H_RES/2 - COVER_W*2;
  localparam int CY0   = V_RES/4 - COVER_H*2;

  s17_t x;
  s17_t y;
  assign x = s17_t'(i_x);
  assign y = s17_t'(i_y);

  logic vs_q;
  logic tick;
  assign tick = i_vs & ~vs_q;

  logic [3:0] btn4;
  assign btn4 = 4'(i_btn);

  logic [HW-1:0] hold [N_BTN];
  logic [VW-1:0] vol_t;
  logic [LW-1:0] vol_q;
  logic [RW-1:0] reveal;
  logic [RW1-1:0] rsum;
  logic vol_evt;
  logic clr;
  logic [LW-1:0] lvl;

  assign vol_evt = btn4[2] | btn4[3] | (i_vol_level != vol_q);
  assign clr = i_restart | btn4[0] | btn4[1];
  assign rsum = RW1'(reveal) + RW1'(REVEAL_STEP);
  assign lvl = (i_vol_level > LW'(VOL_LEVELS)) ?
               LW'(VOL_LEVELS) : i_vol_level;

  // frame tick edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b0;
    else vs_q <= i_vs;
  end

  // per-button highlight timers, press wins over tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_BTN; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_BTN; k++) begin
        if (i_btn[k]) hold[k] <= HW'(HOLD_FRAMES);
        else if (tick && hold[k] != '0)
          hold[k] <= hold[k] - HW'(1);
      end
    end
  end

  // volume bar visibility timer and level change tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_t <= '0;
      vol_q <= '0;
    end else begin
      vol_q <= i_vol_level;
      if (vol_evt) vol_t <= VW'(VOL_FRAMES);
      else if (tick && vol_t != '0) vol_t <= vol_t - VW'(1);
    end
  end

  // cover reveal progress, clear wins, saturates at full cover
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reveal <= '0;
    else if (clr) reveal <= '0;
    else if (tick) begin
      if (rsum >= RW1'(NPIX)) reveal <= RW'(NPIX);
      else reveal <= rsum[RW-1:0];
    end
  end

  logic in_scr, tile_hit, tile_on, in_cov;
  logic bar_hit, seg_lit, in_brd;
  logic [AW-1:0] cov_addr;
  cls_t nx_cls;
  logic [11:0] nx_fix;
  logic nx_latch;
  logic [AW-1:0] nx_addr;

  // region decode and pixel-class selection by priority
  always_comb begin
    in_scr = x >= 0 && x < s17_t'(H_RES) &&
             y >= 0 && y < s17_t'(V_RES);
    tile_hit = 1'b0;
    tile_on = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      if (x >= s17_t'(TX0 + k*PITCH) &&
          x < s17_t'(TX0 + k*PITCH + BTN_SZ) &&
          y >= s17_t'(TY0) && y < s17_t'(TY0 + BTN_SZ)) begin
        tile_hit = 1'b1;
        tile_on = hold[k] != '0;
      end
    end
    in_cov = x >= s17_t'(CX0) && x < s17_t'(CX0 + COVER_W*4) &&
             y >= s17_t'(CY0) && y < s17_t'(CY0 + COVER_H*4);
    cov_addr = AW'(((x - s17_t'(CX0)) >>> 2) +
               ((y - s17_t'(CY0)) >>> 2) * s17_t'(COVER_W));
    bar_hit = x >= s17_t'(VX0) && x < s17_t'(VX0 + SEG_W) &&
              y >= s17_t'(VTOP) && y < s17_t'(VB);
    seg_lit = 1'b0;
    for (int j = 0; j < VOL_LEVELS; j++) begin
      if (y >= s17_t'(VB - (j+1)*SEG_H) &&
          y < s17_t'(VB - j*SEG_H))
        seg_lit = LW'(j) < lvl;
    end
    in_brd = x < s17_t'(BORDER_W) ||
             x >= s17_t'(H_RES - BORDER_W) ||
             y < s17_t'(BORDER_W) ||
             y >= s17_t'(V_RES - BORDER_W);

    nx_cls = C_FIX;
    nx_fix = '0;
    nx_latch = 1'b0;
    nx_addr = '0;
    if (!in_scr) nx_cls = C_FIX;
    else if (tile_hit) nx_fix = tile_on ? 12'hFF0 : 12'hFFF;
    else if (in_cov) begin
      nx_addr = cov_addr;
      if (RW'(cov_addr) < reveal) nx_cls = C_TEX;
      else nx_latch = RW'(cov_addr) == reveal;
    end
    else if (bar_hit && vol_t != '0)
      nx_fix = seg_lit ? 12'h0F0 : 12'h333;
    else if (in_brd) nx_cls = C_BRD;
  end

  cls_t s0_cls;
  logic [11:0] s0_fix;
  logic s0_latch;

  // first stage: register decoded class and ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_cls <= C_FIX;
      s0_fix <= '0;
      s0_latch <= 1'b0;
      o_addr <= '0;
    end else begin
      s0_cls <= nx_cls;
      s0_fix <= nx_fix;
      s0_latch <= nx_latch;
      o_addr <= nx_addr;
    end
  end

  logic [11:0] tex;
  logic [11:0] brd;
  logic brd_ok;
  logic [11:0] rgb;
  assign tex = {i_rom_data[3:0], i_rom_data[7:4], i_rom_data[11:8]};

  // final stage: merge ROM texel and latch border colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= '0;
      brd <= '0;
      brd_ok <= 1'b0;
    end else begin
      if (s0_latch) begin
        brd <= tex;
        brd_ok <= 1'b1;
      end
      unique case (s0_cls)
        C_FIX: rgb <= s0_fix;
        C_TEX: rgb <= tex;
        C_BRD: rgb <= brd_ok ? brd : 12'hFFF;
        default: rgb <= '0;
      endcase
    end
  end

  assign o_red = rgb[11:8];
  assign o_green = rgb[7:4];
  assign o_blue = rgb[3:0];

endmodule

// File: tb/tb_mp3_ui_renderer.sv
// Directed bench for the MP3 UI renderer: static pixels,
// row walks, highlight/volume timers and cover reveal.
module tb_mp3_ui_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [15:0] i_x, i_y;
  logic i_vs;
  logic [3:0] i_btn;
  logic [3:0] i_vol_level;
  logic i_restart;
  logic [11:0] o_addr;
  logic [11:0] i_rom_data;
  logic [3:0] o_red, o_green, o_blue;

  mp3_ui_renderer dut (
    .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_y(i_y),
    .i_vs(i_vs), .i_btn(i_btn), .i_vol_level(i_vol_level),
    .i_restart(i_restart), .o_addr(o_addr),
    .i_rom_data(i_rom_data), .o_red(o_red),
    .o_green(o_green), .o_blue(o_blue)
  );

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return {a[3:0], 1'b1, a[10:8], a[7:4]};
  endfunction

  function automatic logic [11:0] rgb_of(input logic [11:0] d);
    return {d[3:0], d[7:4], d[11:8]};
  endfunction

  assign i_rom_data = rom_f(o_addr);

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pix(input string nm, input int x, input int y,
                     input logic [11:0] exp);
    i_x = 16'(x);
    i_y = 16'(y);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(nm, {o_red, o_green, o_blue}, exp);
  endtask

  task automatic tick();
    i_vs = 1'b1;
    @(posedge clk); #1;
    i_vs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] m);
    i_btn = m;
    @(posedge clk); #1;
    i_btn = '0;
  endtask

  function automatic int tx(input int a);
    return 220 + 4*(a % 50) + 1;
  endfunction

  function automatic int ty(input int a);
    return 20 + 4*(a / 50) + 1;
  endfunction

  function automatic logic [11:0] row360(input int x);
    if (x < 15 || x >= 625) return 12'hFFF;
    for (int k = 0; k < 4; k++)
      if (x >= 208 + 64*k && x < 240 + 64*k) return 12'hFFF;
    return 12'h000;
  endfunction

  typedef struct {
    int x;
    int y;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{-1, 5, 12'h000};
    tbl[1]  = '{640, 5, 12'h000};
    tbl[2]  = '{0, 480, 12'h000};
    tbl[3]  = '{-5, -5, 12'h000};
    tbl[4]  = '{0, 0, 12'hFFF};
    tbl[5]  = '{14, 100, 12'hFFF};
    tbl[6]  = '{15, 100, 12'h000};
    tbl[7]  = '{624, 100, 12'h000};
    tbl[8]  = '{625, 100, 12'hFFF};
    tbl[9]  = '{100, 465, 12'hFFF};
    tbl[10] = '{100, 464, 12'h000};
    tbl[11] = '{239, 391, 12'hFFF};
    tbl[12] = '{240, 360, 12'h000};
    tbl[13] = '{320, 348, 12'h000};

    rst_n = 1'b0;
    i_x = '0; i_y = '0; i_vs = 1'b0; i_btn = '0;
    i_vol_level = '0; i_restart = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset asserted mid-cycle
    pix("tile_pre_rst", 208, 360, 12'hFFF);
    i_x = 16'd241; i_y = 16'd21;
    @(posedge clk); #1;
    check("addr_pre_rst", o_addr, 12'd5);
    check("rgb_pre_rst", {o_red, o_green, o_blue}, 12'hFFF);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", {o_red, o_green, o_blue}, 12'h000);
    check("rst_addr", o_addr, 12'd0);
    @(negedge clk) rst_n = 1'b1;
    pix("border_first", 0, 0, 12'hFFF);

    for (int i = 0; i < 14; i++)
      pix($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].exp);

    // stream row 360; output after an edge is the previous pixel
    i_y = 16'sd360;
    for (int c = 0; c <= 640; c++) begin
      if (c < 640) i_x = 16'(c);
      @(posedge clk); #1;
      if (c >= 1)
        check($sformatf("walk x=%0d", c-1),
              {o_red, o_green, o_blue}, row360(c-1));
    end

    // last cover row: address visible one edge after presentation
    i_y = 16'sd219;
    for (int c = 200; c <= 440; c++) begin
      i_x = 16'(c);
      @(posedge clk); #1;
      check($sformatf("addr x=%0d", c), o_addr,
            (c >= 220 && c < 420) ? 12'((c-220)/4 + 2450) : 12'd0);
    end

    // highlight hold for 8 ticks
    press(4'b0010);
    pix("hl_on", 280, 370, 12'hFF0);
    pix("hl_other", 215, 370, 12'hFFF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      pix($sformatf("hl_t%0d", i), 280, 370,
          i < 8 ? 12'hFF0 : 12'hFFF);
    end

    // retrigger coinciding with tick 5 extends to tick 13
    press(4'b0010);
    for (int i = 1; i <= 4; i++) tick();
    i_vs = 1'b1; i_btn = 4'b0010;
    @(posedge clk); #1;
    i_vs = 1'b0; i_btn = '0;
    @(posedge clk); #1;
    for (int i = 6; i <= 13; i++) begin
      tick();
      if (i >= 12)
        pix($sformatf("rt_t%0d", i), 280, 370,
            i < 13 ? 12'hFF0 : 12'hFFF);
    end
    pix("rt_tile3", 408, 370, 12'hFFF);

    // volume bar
    i_vol_level = 4'd3;
    @(posedge clk); #1;
    pix("v3_seg0", 320, 348, 12'h0F0);
    pix("v3_seg2", 320, 332, 12'h0F0);
    pix("v3_seg3", 320, 324, 12'h333);
    i_vol_level = 4'd5;
    @(posedge clk); #1;
    pix("v5_seg4", 320, 316, 12'h0F0);
    pix("v5_seg5", 320, 308, 12'h333);
    pix("v5_seg7", 320, 292, 12'h333);
    pix("v5_above", 320, 287, 12'h000);
    pix("v5_left", 311, 348, 12'h000);
    pix("v5_edge", 312, 348, 12'h0F0);
    ticks(59);
    pix("v_t59", 320, 348, 12'h0F0);
    tick();
    pix("v_t60", 320, 348, 12'h000);
    i_vol_level = 4'd12;
    @(posedge clk); #1;
    pix("v12_seg7", 320, 292, 12'h0F0);
    ticks(60);
    pix("v12_off", 320, 292, 12'h000);
    press(4'b0100);
    pix("vbtn_seg7", 320, 292, 12'h0F0);

    // cover reveal and border latch
    i_restart = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0;
    pix("rv0_a0", tx(0), ty(0), 12'h000);
    pix("brd_l0", 5, 5, rgb_of(rom_f(12'd0)));
    ticks(100);
    pix("rv100_a99", tx(99), ty(99), rgb_of(rom_f(12'd99)));
    pix("rv100_a100", tx(100), ty(100), 12'h000);
    pix("brd_l100", 5, 5, rgb_of(rom_f(12'd100)));

    i_restart = 1'b1; i_vs = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0; i_vs = 1'b0;
    @(posedge clk); #1;
    pix("clr_a0", tx(0), ty(0), 12'h000);
    pix("clr_a99", tx(99), ty(99), 12'h000);

    ticks(2499);
    pix("rv2499_a2498", tx(2498), ty(2498), rgb_of(rom_f(12'd2498)));
    pix("rv2499_a2499", tx(2499), ty(2499), 12'h000);
    ticks(101);
    pix("sat_a2499", tx(2499), ty(2499), rgb_of(rom_f(12'd2499)));
    ticks(400);
    pix("nowrap_a2499", tx(2499), ty(2499), rgb_of(rom_f(12'd2499)));
    pix("nowrap_a0", tx(0), ty(0), rgb_of(rom_f(12'd0)));
    press(4'b0001);
    pix("prev_clr_a0", tx(0), ty(0), 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
